grf_wb_arbiter: RTL and testbench
=================================

// Module: grf_wb_arbiter
// PURPOSE
// Shares the single GRF write port between the in-order W stage (its Sel_GRF_WD-selected
// write data) and a long-latency MDU result-return path.
// - Buffers MDU results in a small FIFO and arbitrates the port each cycle.
// - Keeps a per-register busy scoreboard so the D stage stalls on registers with an
//   MDU write still pending.
// PARAMETERS
// DEPTH       2   MDU result FIFO entries; also the maximum number of outstanding MDU issues
// STARVE_MAX  4   consecutive cycles a non-empty FIFO head may lose to W before it forces a W stall
// PORTS
// clk           in   1   system clock, rising edge
// reset         in   1   asynchronous, active-high; clears all state
// W_GRF_we      in   1   W-stage write enable
// W_GRF_A3      in   5   W-stage destination register
// W_GRF_WD      in  32   W-stage write data (selected ALU / DM / PC+8 value)
// mdu_issue     in   1   E stage issues an MDU op that will write mdu_issue_A3
// mdu_issue_A3  in   5   destination register of the issued MDU op
// mdu_issue_ready out 1  high when outstanding < DEPTH; E stage must not issue while low
// mdu_valid     in   1   MDU result available
// mdu_A3        in   5   destination register of the MDU result
// mdu_WD        in  32   MDU result data
// mdu_ready     out  1   !fifo_full; result accepted on mdu_valid & mdu_ready
// D_rs, D_rt, D_A3 in 5  D-stage source and destination registers
// stall_D       out  1   D-stage hazard stall
// stall_W       out  1   freeze W and all earlier stages this cycle (forced MDU grant)
// GRF_we        out  1   GRF write enable
// GRF_A3        out  5   GRF write address
// GRF_WD        out 32   GRF write data
// BEHAVIOUR
// - Reset: FIFO empty, starve_cnt=0, busy=32'b0, outstanding=0.
//   Outputs: mdu_ready=1, mdu_issue_ready=1, stall_D=0, stall_W=0, GRF_we=0.
// - GRF_* and stall_* are combinational from current state and inputs.
// - FIFO: push on mdu_valid & mdu_ready. A pushed entry is visible as head the next cycle
//   (minimum MDU write latency: 1 cycle after acceptance).
// - Simultaneous push and pop is legal when full: pop frees the slot only at the next edge,
//   so mdu_ready stays 0 that cycle.
// - w_act = W_GRF_we & (W_GRF_A3 != 0).
// - Head entries with A3 == 0 are popped without using the port (GRF_we=0 for them).
// - force = !empty & (starve_cnt == STARVE_MAX).
// - Grant priority:
//   - force: stall_W=1; port = FIFO head; pop. W holds and retries next cycle.
//   - else if w_act: port = W; if !empty, starve_cnt++.
//   - else if !empty: port = head; pop.
//   - else: GRF_we=0.
// - starve_cnt clears on any pop and whenever the FIFO is empty. It saturates at STARVE_MAX.
// - stall_W is never asserted on two consecutive cycles: force clears starve_cnt.
// - Scoreboard:
//   - busy[mdu_issue_A3] is set on mdu_issue & A3 != 0.
//   - busy[head.A3] is cleared on pop.
//   - Set and clear of the same register in the same cycle: set wins.
//   - busy[0] is always 0.
// - outstanding:
//   - +1 on mdu_issue (including A3 == 0).
//   - -1 on pop.
//   - Both in the same cycle: unchanged.
// - stall_D = busy[D_rs] | busy[D_rt] | busy[D_A3]. The D_A3 term blocks WAW overwrite by a
//   late MDU return.
// - Reset mid-operation discards all pending MDU results. The surrounding pipeline is reset
//   concurrently.
// STRUCTURE
// - Shared package/header: DEPTH and STARVE_MAX defaults, and the Sel_GRF_WD encodings
//   (00 ALU, 01 DM, 10 PC+8) used by the W-stage mux.
// - One sub-module: mdu_wb_fifo (DEPTH x 37-bit sync FIFO: push/pop/full/empty/head).
// - Arbiter, starvation counter and scoreboard live in this module.
// TESTING
// - Reset asserted mid-push with 2 entries queued -> next cycle: empty, mdu_ready=1,
//   busy=0, GRF_we=0.
// - Idle W. MDU issue A3=5 at cycle 0, result mdu_WD=32'h1234 accepted at cycle 3
//   -> GRF_we=1, A3=5, WD=32'h1234 at cycle 4; stall_D with D_rs=5 is high from cycle 1
//   through cycle 4 and low at cycle 5.
// - W writes every cycle (A3=8) with an MDU head pending (A3=9) -> W wins 4 cycles; 5th
//   cycle stall_W=1 and GRF_A3=9; 6th cycle W A3=8 written, stall_W=0.
// - W_GRF_A3=0 with we=1 and FIFO head A3=7 -> head written the same cycle, no stall_W.
//   MDU result with A3=0 -> popped, GRF_we=0.
// - Two issues outstanding -> mdu_issue_ready=0. Pop and new issue (A3=3 both) in the same
//   cycle -> busy[3] remains 1, outstanding unchanged.

Source files
------------

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared types and defaults for the GRF write-back arbiter.
// The W-stage data select encodings live here so the W mux and this block agree.
package grf_wb_arbiter_pkg;
  localparam int DEPTH_DEF      = 2;
  localparam int STARVE_MAX_DEF = 4;

  localparam logic [1:0] SEL_WD_ALU = 2'b00;
  localparam logic [1:0] SEL_WD_DM  = 2'b01;
  localparam logic [1:0] SEL_WD_PC8 = 2'b10;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
  } wb_ent_t;
endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Write-back bundle: W stage, MDU issue/return, D-stage hazard query and GRF write port.
interface grf_wb_arbiter_if;
  logic        W_GRF_we;
  logic [4:0]  W_GRF_A3;
  logic [31:0] W_GRF_WD;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_A3;
  logic        mdu_issue_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_A3;
  logic [31:0] mdu_WD;
  logic        mdu_ready;
  logic [4:0]  D_rs, D_rt, D_A3;
  logic        stall_D, stall_W;
  logic        GRF_we;
  logic [4:0]  GRF_A3;
  logic [31:0] GRF_WD;

  modport slave (
    input  W_GRF_we, W_GRF_A3, W_GRF_WD, mdu_issue, mdu_issue_A3,
           mdu_valid, mdu_A3, mdu_WD, D_rs, D_rt, D_A3,
    output mdu_issue_ready, mdu_ready, stall_D, stall_W, GRF_we, GRF_A3, GRF_WD
  );
  modport master (
    output W_GRF_we, W_GRF_A3, W_GRF_WD, mdu_issue, mdu_issue_A3,
           mdu_valid, mdu_A3, mdu_WD, D_rs, D_rt, D_A3,
    input  mdu_issue_ready, mdu_ready, stall_D, stall_W, GRF_we, GRF_A3, GRF_WD
  );
endinterface

// File: rtl/grf_wb_arbiter_mdu_wb_fifo.sv
// Small synchronous FIFO holding returned MDU results until the GRF port is free.
module mdu_wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_ent_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_ent_t head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_ent_t         mem_q [DEPTH];
  wb_ent_t         mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign head   = mem_q[rd_ptr_q];
  assign do_pop = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    // A full FIFO never sees push, so a simultaneous pop cannot overflow.
    case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/grf_wb_arbiter.sv
// Arbitrates the single GRF write port between the W stage and buffered MDU results,
// and tracks which registers still have an MDU write in flight.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  grf_wb_arbiter_if.slave   bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int OW = $clog2(DEPTH + 1);

  logic          full, empty, push, pop;
  wb_ent_t       head, push_ent;
  logic          w_act, head_nz, force_g;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   busy_q, busy_d;
  logic [OW-1:0] outst_q, outst_d;

  assign push     = bus.mdu_valid & ~full;
  assign push_ent = {bus.mdu_A3, bus.mdu_WD};

  mdu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign bus.mdu_ready       = ~full;
  assign bus.mdu_issue_ready = (outst_q < OW'(DEPTH));
  assign bus.stall_D         = busy_q[bus.D_rs] | busy_q[bus.D_rt] | busy_q[bus.D_A3];

  assign w_act   = bus.W_GRF_we & (bus.W_GRF_A3 != 5'd0);
  assign head_nz = (head.a3 != 5'd0);
  assign force_g = ~empty & head_nz & (starve_q == SW'(STARVE_MAX));

  always_comb begin
    pop         = 1'b0;
    bus.stall_W = 1'b0;
    bus.GRF_we  = 1'b0;
    bus.GRF_A3  = 5'd0;
    bus.GRF_WD  = 32'd0;
    // An r0 result is discarded without occupying the port, so W may still write.
    if (!empty && !head_nz) begin
      pop = 1'b1;
      if (w_act) begin
        bus.GRF_we = 1'b1;
        bus.GRF_A3 = bus.W_GRF_A3;
        bus.GRF_WD = bus.W_GRF_WD;
      end
    end else if (force_g) begin
      pop         = 1'b1;
      bus.stall_W = 1'b1;
      bus.GRF_we  = 1'b1;
      bus.GRF_A3  = head.a3;
      bus.GRF_WD  = head.wd;
    end else if (w_act) begin
      bus.GRF_we = 1'b1;
      bus.GRF_A3 = bus.W_GRF_A3;
      bus.GRF_WD = bus.W_GRF_WD;
    end else if (!empty) begin
      pop        = 1'b1;
      bus.GRF_we = 1'b1;
      bus.GRF_A3 = head.a3;
      bus.GRF_WD = head.wd;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || pop)                           starve_d = '0;
    else if (w_act && starve_q != SW'(STARVE_MAX)) starve_d = starve_q + SW'(1);

    busy_d = busy_q;
    if (pop) busy_d[head.a3] = 1'b0;
    // Issue is applied after the pop clear so a same-register re-issue stays busy.
    if (bus.mdu_issue && bus.mdu_issue_A3 != 5'd0) busy_d[bus.mdu_issue_A3] = 1'b1;
    busy_d[0] = 1'b0;

    case ({bus.mdu_issue, pop})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      busy_q   <= '0;
      outst_q  <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
      outst_q  <= outst_d;
    end
  end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench: expected GRF writes go into a scoreboard queue, a negedge monitor checks them.
module tb_grf_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  grf_wb_arbiter_if bus();
  grf_wb_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct { logic [4:0] a3; logic [31:0] wd; logic sw; } exp_t;
  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d, input logic sw);
    exp_t e;
    e.a3 = a; e.wd = d; e.sw = sw;
    sb.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Monitor: every GRF write must match the head of the scoreboard, and vice versa.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.GRF_we) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got A3=%0d WD=%h, expected no write", bus.GRF_A3, bus.GRF_WD);
          end else begin
            e = sb.pop_front();
            if (bus.GRF_A3 !== e.a3 || bus.GRF_WD !== e.wd || bus.stall_W !== e.sw) begin
              fails++;
              $display("FAIL grf_write: got A3=%0d WD=%h stall_W=%b expected A3=%0d WD=%h stall_W=%b",
                       bus.GRF_A3, bus.GRF_WD, bus.stall_W, e.a3, e.wd, e.sw);
            end
          end
        end else if (sb.size() != 0) begin
          tests++;
          fails++;
          e = sb.pop_front();
          $display("FAIL missing_write: got no write expected A3=%0d WD=%h", e.a3, e.wd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.W_GRF_we = 0; bus.W_GRF_A3 = 0; bus.W_GRF_WD = 0;
    bus.mdu_issue = 0; bus.mdu_issue_A3 = 0;
    bus.mdu_valid = 0; bus.mdu_A3 = 0; bus.mdu_WD = 0;
    bus.D_rs = 0; bus.D_rt = 0; bus.D_A3 = 0;

    // Reset state
    neg();
    chk("rst_mdu_ready", bus.mdu_ready, 1);
    chk("rst_issue_ready", bus.mdu_issue_ready, 1);
    chk("rst_stall_D", bus.stall_D, 0);
    chk("rst_stall_W", bus.stall_W, 0);
    chk("rst_GRF_we", bus.GRF_we, 0);
    nxt(); reset = 0; nxt();

    // Basic MDU round trip, idle W
    bus.D_rs = 5; bus.mdu_issue = 1; bus.mdu_issue_A3 = 5;
    neg(); chk("A_stallD_c0", bus.stall_D, 0); nxt();
    bus.mdu_issue = 0;
    neg(); chk("A_stallD_c1", bus.stall_D, 1); nxt();
    neg(); chk("A_stallD_c2", bus.stall_D, 1); nxt();
    bus.mdu_valid = 1; bus.mdu_A3 = 5; bus.mdu_WD = 32'h1234;
    neg(); chk("A_mdu_ready_c3", bus.mdu_ready, 1); chk("A_stallD_c3", bus.stall_D, 1); nxt();
    bus.mdu_valid = 0; exp_wr(5, 32'h1234, 0);
    neg(); chk("A_stallD_c4", bus.stall_D, 1); nxt();
    neg(); chk("A_stallD_c5", bus.stall_D, 0); nxt();
    bus.D_rs = 0;

    // Starvation: W writes every cycle while head A3=9 waits
    bus.mdu_issue = 1; bus.mdu_issue_A3 = 9;
    neg(); nxt();
    bus.mdu_issue = 0;
    bus.mdu_valid = 1; bus.mdu_A3 = 9; bus.mdu_WD = 32'h9999;
    bus.W_GRF_we = 1; bus.W_GRF_A3 = 8; bus.W_GRF_WD = 32'h801; exp_wr(8, 32'h801, 0);
    neg(); nxt();
    bus.mdu_valid = 0; bus.D_A3 = 9;
    for (int i = 2; i <= 5; i++) begin
      bus.W_GRF_WD = 32'h800 + i; exp_wr(8, 32'h800 + i, 0);
      neg();
      chk("S_stallW_w", bus.stall_W, 0);
      if (i == 2) chk("S_stallD_waw", bus.stall_D, 1);
      nxt();
    end
    bus.W_GRF_WD = 32'h806; exp_wr(9, 32'h9999, 1);
    neg(); chk("S_stallW_force", bus.stall_W, 1); nxt();
    exp_wr(8, 32'h806, 0);
    neg(); chk("S_stallW_after", bus.stall_W, 0); chk("S_stallD_clr", bus.stall_D, 0); nxt();
    bus.W_GRF_we = 0; bus.D_A3 = 0;

    // W to r0 does not block the port; r0 MDU results are dropped
    bus.mdu_issue = 1; bus.mdu_issue_A3 = 7;
    neg(); nxt();
    bus.mdu_issue = 0; bus.mdu_valid = 1; bus.mdu_A3 = 7; bus.mdu_WD = 32'h7777;
    neg(); nxt();
    bus.mdu_valid = 0; bus.W_GRF_we = 1; bus.W_GRF_A3 = 0; bus.W_GRF_WD = 32'hdead;
    exp_wr(7, 32'h7777, 0);
    neg(); chk("Z_stallW", bus.stall_W, 0); nxt();
    bus.W_GRF_we = 0; bus.mdu_issue = 1; bus.mdu_issue_A3 = 0;
    neg(); nxt();
    bus.mdu_issue = 0; bus.mdu_valid = 1; bus.mdu_A3 = 0; bus.mdu_WD = 32'h5;
    neg(); nxt();
    bus.mdu_valid = 0;
    neg(); chk("Z_r0_GRF_we", bus.GRF_we, 0); nxt();
    bus.mdu_issue = 1; bus.mdu_issue_A3 = 11;
    neg(); nxt();
    bus.mdu_issue = 0; bus.mdu_valid = 1; bus.mdu_A3 = 11; bus.mdu_WD = 32'hB;
    neg(); chk("Z_r0_popped_outst", bus.mdu_issue_ready, 1); nxt();
    bus.mdu_valid = 0; exp_wr(11, 32'hB, 0);
    neg(); nxt();

    // Outstanding limit and same-cycle pop/issue of one register
    bus.D_rs = 3; bus.mdu_issue = 1; bus.mdu_issue_A3 = 3;
    neg(); nxt();
    bus.mdu_issue_A3 = 4;
    neg(); nxt();
    bus.mdu_issue = 0; bus.mdu_valid = 1; bus.mdu_A3 = 4; bus.mdu_WD = 32'h44;
    neg(); chk("O_issue_ready_full", bus.mdu_issue_ready, 0); chk("O_stallD3", bus.stall_D, 1); nxt();
    bus.mdu_valid = 0; exp_wr(4, 32'h44, 0);
    neg(); chk("O_issue_ready_pop", bus.mdu_issue_ready, 0); nxt();
    bus.mdu_valid = 1; bus.mdu_A3 = 3; bus.mdu_WD = 32'h33;
    neg(); chk("O_issue_ready_one", bus.mdu_issue_ready, 1); nxt();
    bus.mdu_valid = 0; bus.mdu_issue = 1; bus.mdu_issue_A3 = 3; exp_wr(3, 32'h33, 0);
    neg(); nxt();
    bus.mdu_issue_A3 = 10;
    neg(); chk("O_busy3_kept", bus.stall_D, 1); chk("O_outst_same", bus.mdu_issue_ready, 1); nxt();
    bus.mdu_issue = 0; bus.mdu_valid = 1; bus.mdu_A3 = 3; bus.mdu_WD = 32'h31;
    neg(); chk("O_issue_ready_two", bus.mdu_issue_ready, 0); nxt();
    bus.mdu_A3 = 10; bus.mdu_WD = 32'h1010; exp_wr(3, 32'h31, 0);
    neg(); nxt();
    bus.mdu_valid = 0; exp_wr(10, 32'h1010, 0);
    neg(); nxt();
    neg(); chk("O_stallD_clr", bus.stall_D, 0); chk("O_issue_ready_end", bus.mdu_issue_ready, 1); nxt();
    bus.D_rs = 0;

    // Fill the FIFO behind W, then reset mid-push
    bus.mdu_issue = 1; bus.mdu_issue_A3 = 1;
    neg(); nxt();
    bus.mdu_issue_A3 = 2;
    bus.W_GRF_we = 1; bus.W_GRF_A3 = 20; bus.W_GRF_WD = 32'h2001; exp_wr(20, 32'h2001, 0);
    neg(); nxt();
    bus.mdu_issue = 0; bus.mdu_valid = 1; bus.mdu_A3 = 1; bus.mdu_WD = 32'h11;
    bus.W_GRF_WD = 32'h2002; exp_wr(20, 32'h2002, 0);
    neg(); nxt();
    bus.mdu_A3 = 2; bus.mdu_WD = 32'h22;
    bus.W_GRF_WD = 32'h2003; exp_wr(20, 32'h2003, 0);
    neg(); nxt();
    bus.mdu_A3 = 6; bus.mdu_WD = 32'h66;
    bus.W_GRF_WD = 32'h2004; exp_wr(20, 32'h2004, 0);
    neg(); chk("R_full_ready", bus.mdu_ready, 0); nxt();
    reset = 1; bus.W_GRF_we = 0;
    neg(); chk("R_in_rst_ready", bus.mdu_ready, 1); chk("R_in_rst_we", bus.GRF_we, 0); nxt();
    reset = 0; bus.mdu_valid = 0; bus.D_rs = 1; bus.D_rt = 2;
    neg();
    chk("R_mdu_ready", bus.mdu_ready, 1);
    chk("R_issue_ready", bus.mdu_issue_ready, 1);
    chk("R_busy", bus.stall_D, 0);
    chk("R_GRF_we", bus.GRF_we, 0);
    nxt();
    neg(); chk("R_GRF_we_next", bus.GRF_we, 0); nxt();
    neg(); nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
